peridot_swi_mbox: RTL and testbench
===================================

Name: peridot_swi_mbox

Overview:
Multi-channel software-interrupt, mailbox and mutex block for PERIDOT Avalon-MM systems. It is the parametrised successor of the single-bit SWI sender. It provides CHANNELS independent maskable interrupt flags, settable by software or by external trigger edges, plus a hardware mutex with owner ID and a message FIFO. A deadkey-protected CPU reset and LED control are retained; the boot SPI-Flash is not part of this block.

Parameters:
CLASSID, 32'h72A00001, class index returned at reg0
TIMECODE, 32'd1234567890, generation timestamp returned at reg1
CHANNELS, 8, number of SWI channels, 1..32
FIFO_DEPTH, 16, message FIFO entries; power of 2, 2..256
TRIG_SYNC, 1, 1 = 2-FF synchronise coe_trig; 0 = coe_trig is already in the clock_sig domain

Ports:
clock_sig  in  1  clock; all logic rising-edge
reset_sig  in  1  reset, asynchronous, active-high
avs_address  in  4  register word address
avs_read  in  1  read strobe; zero wait states, readdata combinational
avs_readdata  out  32  read data
avs_write  in  1  write strobe
avs_writedata  in  32  write data
ins_irq  out  1  interrupt request
coe_trig  in  CHANNELS  external trigger; a rising edge sets the matching pending bit
coe_cpureset  out  1  CPU reset request
coe_led  out  1  LED drive

Behaviour:
Register map; unmapped reads return 0 and unmapped writes are ignored:
- reg0 CLASSID (RO). reg1 TIMECODE (RO).
- reg2: bit1 led (RW); bit0 cpureset (RW). bit0 is written only when wdata[31:16]==16'hDEAD; bit1 is always written.
- reg3 PEND: read returns pending[CHANNELS-1:0]; a write sets pending bits where wdata=1 (W1S).
- reg4 PEND: same read; a write clears pending bits where wdata=1 (W1C).
- reg5 MASK (RW), bits [CHANNELS-1:0].
- reg6 MUTEX: {owner[31:16], value[15:0]}.
- reg7 MBOX DATA.
- reg8 MBOX STAT: bit24 rxirqena (RW), bit18 ovf (sticky, W1C), bit17 full, bit16 empty, bits[8:0] count.
Reset values: pending=0, mask=0, mutex=0, FIFO empty, ovf=0, rxirqena=0, cpureset=0, led=0. Hence ins_irq=0, coe_cpureset=0, coe_led=0.
ins_irq = |(pending & mask) | (rxirqena & ~empty). Registered terms only; no combinational path from the bus.
Triggers:
- Optional 2-FF synchroniser, then a registered edge detector.
- A pending bit sets 1 cycle after the synchronised rising edge (3 cycles from the coe_trig edge when TRIG_SYNC=1).
- Trigger set and reg4 clear in the same cycle on the same bit: set wins, bit stays 1.
- reg3 and trigger set in the same cycle: bit is 1.
Mutex write rule:
- If current owner==0, or wdata[31:16]==current owner, then the write is accepted.
- An accepted write with wdata[15:0]==0 releases: owner and value both go to 0.
- Otherwise the accepted write loads owner=wdata[31:16], value=wdata[15:0].
- A write with wdata[31:16]==0 is always ignored.
- Non-matching writes are ignored silently; software verifies ownership by reading back.
Mailbox:
- Write to reg7: push if not full. If full, data is dropped and ovf is set.
- Read of reg7 with avs_read=1: returns head and pops if not empty. Pop takes effect at the clock edge ending the read cycle.
- Read of reg7 when empty: returns 32'h0, no state change.
- Each read cycle pops exactly one word; the bus master must not hold avs_read across multiple cycles for one transfer.
- count is 0..FIFO_DEPTH. Pointers wrap modulo FIFO_DEPTH. full = (count==FIFO_DEPTH).
- ovf and count update on the same edge as the push or pop.
Reset mid-operation: asynchronous reset clears everything, including FIFO contents and synchroniser flops. The trigger edge detector resets with previous=0, so a coe_trig held high through reset produces one pending set after release.

Decomposition:
Package peridot_swi_pkg holds:
- register address constants REG_CLASS..REG_MBSTAT (0..8)
- DEADKEY=16'hDEAD
- MBSTAT bit positions (OVF, FULL, EMPTY, RXIRQENA)
- mutex field slices
Sub-module peridot_swi_fifo: synchronous single-clock FIFO.
- Parameters: WIDTH, DEPTH.
- Ports: push, pop, wdata, rdata (show-ahead), count, full, empty.
- Push-when-full and pop-when-empty are ignored internally.
- The top level handles ovf.

Test Plan:
1. Reset, then read reg0/reg1/reg8 -> 32'h72A00001, 1234567890, 32'h00010000. ins_irq=0, coe_cpureset=0.
2. Write reg2 0x00000003 -> led=1, cpureset=0. Write 0xDEAD0001 -> cpureset=1, led=0. Write 0x12340000 -> cpureset stays 1.
3. Write reg5=0x05, then reg3=0x06 -> PEND=0x06, ins_irq=1 (bit2 unmasked). Write reg4=0x04 -> PEND=0x02, ins_irq=0.
4. Pulse coe_trig[3] in the same cycle that a synchronised edge meets a reg4 write of 0x08 -> PEND bit3=1 (set wins). Edge-to-pending latency is 3 cycles with TRIG_SYNC=1.
5. Mutex:
   - Write 0x00010005 -> reads back 0x00010005.
   - Write 0x00020007 -> unchanged.
   - Write 0x00010000 -> reads 0.
   - Write 0x00020007 -> reads 0x00020007.
6. Mailbox, FIFO_DEPTH=16:
   - Set rxirqena, push 17 words 1..17 -> count=16, full=1, ovf=1, ins_irq=1.
   - 16 reads -> return 1..16 in order.
   - 17th read -> 0, count=0, ins_irq=0.
   - Write reg8 bit18 -> ovf=0.

Source files
------------

// File: rtl/peridot_swi_pkg.sv
// Shared constants for the PERIDOT SWI / mailbox / mutex block.
// Register map, deadkey and status/mutex field positions.
package peridot_swi_pkg;

  localparam logic [3:0] REG_CLASS  = 4'd0;
  localparam logic [3:0] REG_TIME   = 4'd1;
  localparam logic [3:0] REG_CTRL   = 4'd2;
  localparam logic [3:0] REG_PSET   = 4'd3;
  localparam logic [3:0] REG_PCLR   = 4'd4;
  localparam logic [3:0] REG_MASK   = 4'd5;
  localparam logic [3:0] REG_MUTEX  = 4'd6;
  localparam logic [3:0] REG_MBDATA = 4'd7;
  localparam logic [3:0] REG_MBSTAT = 4'd8;

  localparam logic [15:0] DEADKEY = 16'hDEAD;

  localparam int MBSTAT_RXIRQENA = 24;
  localparam int MBSTAT_OVF      = 18;
  localparam int MBSTAT_FULL     = 17;
  localparam int MBSTAT_EMPTY    = 16;

  localparam int MTX_OWN_HI = 31;
  localparam int MTX_OWN_LO = 16;
  localparam int MTX_VAL_HI = 15;
  localparam int MTX_VAL_LO = 0;

endpackage

// File: rtl/peridot_swi_fifo.sv
// Single-clock show-ahead FIFO for the SWI mailbox.
// Push when full and pop when empty are silently ignored.
module peridot_swi_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clock_sig,
  input  logic             reset_sig,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clock_sig or posedge reset_sig) begin
    if (reset_sig) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/peridot_swi_mbox.sv
// Multi-channel SWI flags, hardware mutex and message mailbox
// with deadkey-protected CPU reset and LED control.
module peridot_swi_mbox
  import peridot_swi_pkg::*;
#(
  parameter logic [31:0] CLASSID    = 32'h72A00001,
  parameter logic [31:0] TIMECODE   = 32'd1234567890,
  parameter int          CHANNELS   = 8,
  parameter int          FIFO_DEPTH = 16,
  parameter int          TRIG_SYNC  = 1
) (
  input  logic                clock_sig,
  input  logic                reset_sig,
  input  logic [3:0]          avs_address,
  input  logic                avs_read,
  output logic [31:0]         avs_readdata,
  input  logic                avs_write,
  input  logic [31:0]         avs_writedata,
  output logic                ins_irq,
  input  logic [CHANNELS-1:0] coe_trig,
  output logic                coe_cpureset,
  output logic                coe_led
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [CHANNELS-1:0] pend, pend_n, mask;
  logic [CHANNELS-1:0] trig_s, trig_p, rise, wbits;
  logic [15:0]         owner, value;
  logic [15:0]         w_own, w_val;
  logic                ovf, rxirqena;
  logic [31:0]         fifo_rdata;
  logic [CW-1:0]       count;
  logic                full, empty;
  logic                wr_ctrl, wr_pset, wr_pclr, wr_mask;
  logic                wr_mtx, wr_mbd, wr_stat, rd_mbd;
  logic                mtx_ok;

  assign wr_ctrl = avs_write && (avs_address == REG_CTRL);
  assign wr_pset = avs_write && (avs_address == REG_PSET);
  assign wr_pclr = avs_write && (avs_address == REG_PCLR);
  assign wr_mask = avs_write && (avs_address == REG_MASK);
  assign wr_mtx  = avs_write && (avs_address == REG_MUTEX);
  assign wr_mbd  = avs_write && (avs_address == REG_MBDATA);
  assign wr_stat = avs_write && (avs_address == REG_MBSTAT);
  assign rd_mbd  = avs_read && (avs_address == REG_MBDATA);

  assign wbits = avs_writedata[CHANNELS-1:0];
  assign w_own = avs_writedata[MTX_OWN_HI:MTX_OWN_LO];
  assign w_val = avs_writedata[MTX_VAL_HI:MTX_VAL_LO];

  if (TRIG_SYNC != 0) begin : g_sync
    logic [CHANNELS-1:0] s1, s2;
    always_ff @(posedge clock_sig or posedge reset_sig) begin
      if (reset_sig) begin
        s1 <= '0;
        s2 <= '0;
      end else begin
        s1 <= coe_trig;
        s2 <= s1;
      end
    end
    assign trig_s = s2;
  end else begin : g_nosync
    assign trig_s = coe_trig;
  end

  // Trigger set is OR'd last so it wins over a same-cycle W1C.
  assign rise   = trig_s & ~trig_p;
  assign pend_n = ((pend | (wr_pset ? wbits : '0))
                 & ~(wr_pclr ? wbits : '0)) | rise;

  assign mtx_ok = (w_own != '0) && ((owner == '0) || (w_own == owner));

  always_ff @(posedge clock_sig or posedge reset_sig) begin
    if (reset_sig) begin
      trig_p       <= '0;
      pend         <= '0;
      mask         <= '0;
      owner        <= '0;
      value        <= '0;
      ovf          <= 1'b0;
      rxirqena     <= 1'b0;
      coe_cpureset <= 1'b0;
      coe_led      <= 1'b0;
    end else begin
      trig_p <= trig_s;
      pend   <= pend_n;
      if (wr_mask) mask <= wbits;
      if (wr_ctrl) begin
        coe_led <= avs_writedata[1];
        if (avs_writedata[31:16] == DEADKEY)
          coe_cpureset <= avs_writedata[0];
      end
      if (wr_mtx && mtx_ok) begin
        owner <= (w_val == '0) ? '0 : w_own;
        value <= w_val;
      end
      if (wr_stat) rxirqena <= avs_writedata[MBSTAT_RXIRQENA];
      ovf <= (ovf & ~(wr_stat & avs_writedata[MBSTAT_OVF]))
           | (wr_mbd & full);
    end
  end

  peridot_swi_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock_sig (clock_sig),
    .reset_sig (reset_sig),
    .push      (wr_mbd),
    .pop       (rd_mbd),
    .wdata     (avs_writedata),
    .rdata     (fifo_rdata),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  assign ins_irq = (|(pend & mask)) | (rxirqena & ~empty);

  always_comb begin
    avs_readdata = '0;
    case (avs_address)
      REG_CLASS:  avs_readdata = CLASSID;
      REG_TIME:   avs_readdata = TIMECODE;
      REG_CTRL:   avs_readdata = {30'd0, coe_led, coe_cpureset};
      REG_PSET,
      REG_PCLR:   avs_readdata = 32'(pend);
      REG_MASK:   avs_readdata = 32'(mask);
      REG_MUTEX:  avs_readdata = {owner, value};
      REG_MBDATA: avs_readdata = empty ? '0 : fifo_rdata;
      REG_MBSTAT: begin
        avs_readdata[MBSTAT_RXIRQENA] = rxirqena;
        avs_readdata[MBSTAT_OVF]      = ovf;
        avs_readdata[MBSTAT_FULL]     = full;
        avs_readdata[MBSTAT_EMPTY]    = empty;
        avs_readdata[8:0]             = 9'(count);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_peridot_swi_mbox.sv
// Self-checking bench for peridot_swi_mbox with a read-data scoreboard.
module tb_peridot_swi_mbox;

  logic        clock_sig = 1'b0;
  logic        reset_sig = 1'b1;
  logic [3:0]  avs_address = '0;
  logic        avs_read = 1'b0;
  logic [31:0] avs_readdata;
  logic        avs_write = 1'b0;
  logic [31:0] avs_writedata = '0;
  logic        ins_irq;
  logic [7:0]  coe_trig = '0;
  logic        coe_cpureset;
  logic        coe_led;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  always #5 clock_sig = ~clock_sig;

  peridot_swi_mbox dut (
    .clock_sig     (clock_sig),
    .reset_sig     (reset_sig),
    .avs_address   (avs_address),
    .avs_read      (avs_read),
    .avs_readdata  (avs_readdata),
    .avs_write     (avs_write),
    .avs_writedata (avs_writedata),
    .ins_irq       (ins_irq),
    .coe_trig      (coe_trig),
    .coe_cpureset  (coe_cpureset),
    .coe_led       (coe_led)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock_sig);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    avs_address   = a;
    avs_writedata = d;
    avs_write     = 1'b1;
    step();
    avs_write     = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [3:0] a,
                    input logic [31:0] exp);
    logic [31:0] e;
    avs_address = a;
    avs_read    = 1'b1;
    exp_q.push_back(exp);
    @(negedge clock_sig);
    e = exp_q.pop_front();
    check(tag, avs_readdata, e);
    step();
    avs_read = 1'b0;
  endtask

  initial begin
    repeat (3) step();
    reset_sig = 1'b0;
    step();

    rd("class", 4'd0, 32'h72A00001);
    rd("time", 4'd1, 32'd1234567890);
    rd("stat_rst", 4'd8, 32'h00010000);
    check("irq_rst", 32'(ins_irq), 32'd0);
    check("cpurst_rst", 32'(coe_cpureset), 32'd0);

    wr(4'd2, 32'h00000003);
    check("led_on", 32'(coe_led), 32'd1);
    check("cpurst_nokey", 32'(coe_cpureset), 32'd0);
    wr(4'd2, 32'hDEAD0001);
    check("cpurst_key", 32'(coe_cpureset), 32'd1);
    check("led_off", 32'(coe_led), 32'd0);
    wr(4'd2, 32'h12340000);
    check("cpurst_hold", 32'(coe_cpureset), 32'd1);

    wr(4'd5, 32'h05);
    wr(4'd3, 32'h06);
    rd("pend_w1s", 4'd3, 32'h06);
    check("irq_pend", 32'(ins_irq), 32'd1);
    wr(4'd4, 32'h04);
    rd("pend_w1c", 4'd4, 32'h02);
    check("irq_clr", 32'(ins_irq), 32'd0);

    wr(4'd5, 32'h08);
    coe_trig[3] = 1'b1;
    step();
    step();
    check("trig_lat2", 32'(ins_irq), 32'd0);
    step();
    check("trig_lat3", 32'(ins_irq), 32'd1);
    coe_trig[3] = 1'b0;
    wr(4'd4, 32'h08);
    rd("pend_trigclr", 4'd3, 32'h02);
    repeat (4) step();
    coe_trig[3] = 1'b1;
    step();
    step();
    wr(4'd4, 32'h08);
    rd("pend_setwins", 4'd3, 32'h0A);
    coe_trig[3] = 1'b0;

    wr(4'd6, 32'h00010005);
    rd("mtx_take", 4'd6, 32'h00010005);
    wr(4'd6, 32'h00020007);
    rd("mtx_deny", 4'd6, 32'h00010005);
    wr(4'd6, 32'h00000009);
    rd("mtx_zero", 4'd6, 32'h00010005);
    wr(4'd6, 32'h00010000);
    rd("mtx_rel", 4'd6, 32'h00000000);
    wr(4'd6, 32'h00020007);
    rd("mtx_new", 4'd6, 32'h00020007);

    wr(4'd5, 32'h00);
    wr(4'd4, 32'hFF);
    check("irq_idle", 32'(ins_irq), 32'd0);
    wr(4'd8, 32'h01000000);
    for (int i = 1; i <= 17; i++) wr(4'd7, 32'(i));
    rd("stat_full", 4'd8, 32'h01060010);
    check("irq_rx", 32'(ins_irq), 32'd1);
    for (int i = 1; i <= 16; i++) rd($sformatf("mb_%0d", i), 4'd7, 32'(i));
    rd("mb_empty", 4'd7, 32'h0);
    rd("stat_drain", 4'd8, 32'h01050000);
    check("irq_drain", 32'(ins_irq), 32'd0);
    wr(4'd8, 32'h01040000);
    rd("stat_ovfclr", 4'd8, 32'h01010000);

    wr(4'd7, 32'hAA);
    wr(4'd7, 32'hBB);
    rd("stat_two", 4'd8, 32'h01000002);
    coe_trig[0] = 1'b1;
    reset_sig   = 1'b1;
    step();
    step();
    reset_sig = 1'b0;
    rd("stat_rst2", 4'd8, 32'h00010000);
    wr(4'd5, 32'h01);
    rd("pend_rst_lat", 4'd3, 32'h00);
    rd("pend_rst_hold", 4'd3, 32'h01);
    check("irq_rst_hold", 32'(ins_irq), 32'd1);
    coe_trig[0] = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
